// File: rtl/alu_arb_pkg.sv
// Shared types for the main_alu arbiter.
// Holds the requester id and the per-stage in-flight tracking record.
package alu_arb_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int OPSEL_W_DEF = 4;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t owner;
  } stage_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot combinational grant.
// The pointer names the requester that wins a tie and moves past every winner.
module rr_arbiter2
  import alu_arb_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_valid,
  output logic [1:0] o_grant
);

  req_id_t ptr_q, ptr_d;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = (ptr_q == REQ0) ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (o_grant[0]) begin
      ptr_d = REQ1;
    end else if (o_grant[1]) begin
      ptr_d = REQ0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_q <= REQ0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/main_alu_arbiter.sv
// Shares one registered main_alu between two requesters, tracks each op's owner
// through the ALU latency and returns the result as a one-cycle response pulse.
module main_alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int XLEN        = XLEN_DEF,
  parameter int OPSEL_W     = OPSEL_W_DEF,
  parameter int ALU_LATENCY = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [XLEN-1:0]    i_req0_op1,
  input  logic [XLEN-1:0]    i_req0_op2,
  input  logic [OPSEL_W-1:0] i_req0_opsel,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [XLEN-1:0]    i_req1_op1,
  input  logic [XLEN-1:0]    i_req1_op2,
  input  logic [OPSEL_W-1:0] i_req1_opsel,
  input  logic [1:0]         i_flush,
  output logic [XLEN-1:0]    o_alu_op1,
  output logic [XLEN-1:0]    o_alu_op2,
  output logic [OPSEL_W-1:0] o_alu_opsel,
  input  logic [XLEN-1:0]    i_alu_out,
  output logic               o_rsp0_valid,
  output logic               o_rsp1_valid,
  output logic [XLEN-1:0]    o_rsp_data,
  output logic               o_busy
);

  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       issue;
  req_id_t    grant_id;

  // Requests are masked while reset is held so ready and the ALU drive read zero at once.
  assign req_valid = {i_req1_valid, i_req0_valid} & {2{i_rst_n}};

  rr_arbiter2 u_rr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_valid (req_valid),
    .o_grant (grant)
  );

  assign o_req0_ready = grant[0];
  assign o_req1_ready = grant[1];
  assign issue        = |grant;
  assign grant_id     = grant[1] ? REQ1 : REQ0;

  always_comb begin
    o_alu_op1   = '0;
    o_alu_op2   = '0;
    o_alu_opsel = '0;
    if (grant[0]) begin
      o_alu_op1   = i_req0_op1;
      o_alu_op2   = i_req0_op2;
      o_alu_opsel = i_req0_opsel;
    end else if (grant[1]) begin
      o_alu_op1   = i_req1_op1;
      o_alu_op2   = i_req1_op2;
      o_alu_opsel = i_req1_opsel;
    end
  end

  stage_t [ALU_LATENCY-1:0] stage_q;
  stage_t [ALU_LATENCY-1:0] stage_d;
  stage_t [ALU_LATENCY-1:0] stage_live;
  stage_t                   out_stage;

  // A flush kills matching stages this cycle, including the one being presented as a response.
  always_comb begin
    stage_live = stage_q;
    for (int k = 0; k < ALU_LATENCY; k++) begin
      if (i_flush[stage_q[k].owner]) begin
        stage_live[k].valid = 1'b0;
      end
    end
  end

  always_comb begin
    stage_d          = '0;
    stage_d[0].valid = issue & ~i_flush[grant_id];
    stage_d[0].owner = grant_id;
    for (int k = 1; k < ALU_LATENCY; k++) begin
      stage_d[k] = stage_live[k-1];
    end
  end

  // NOTE: only the tracking bits need reset; result data is never stored here.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign out_stage    = stage_live[ALU_LATENCY-1];
  assign o_rsp0_valid = out_stage.valid && (out_stage.owner == REQ0);
  assign o_rsp1_valid = out_stage.valid && (out_stage.owner == REQ1);
  assign o_rsp_data   = out_stage.valid ? i_alu_out : '0;

  always_comb begin
    o_busy = 1'b0;
    for (int k = 0; k < ALU_LATENCY; k++) begin
      o_busy = o_busy | stage_live[k].valid;
    end
  end

endmodule

// File: tb/tb_main_alu_arbiter.sv
// Directed bench: three arbiters (ALU latency 1, 2, 3) share one stimulus stream,
// each fed by its own behavioural main_alu delay line.
module tb_main_alu_arbiter;

  logic        clk;
  logic        rst_n;
  logic        v0, v1;
  logic [31:0] r0_op1, r0_op2, r1_op1, r1_op2;
  logic [3:0]  r0_sel, r1_sel;
  logic [1:0]  flush;

  logic [2:0]       ready0, ready1, rsp0, rsp1, busy;
  logic [2:0][31:0] alu_op1, alu_op2, alu_out, rsp_data;
  logic [2:0][3:0]  alu_sel;

  int checks = 0;
  int fails  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] s);
    case (s)
      4'd0:    return a + b;
      4'd1:    return a - b;
      default: return a ^ b;
    endcase
  endfunction

  for (genvar li = 0; li < 3; li++) begin : g_dut
    logic [31:0] dl [4];

    main_alu_arbiter #(
      .XLEN        (32),
      .OPSEL_W     (4),
      .ALU_LATENCY (li + 1)
    ) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_req0_valid (v0),
      .o_req0_ready (ready0[li]),
      .i_req0_op1   (r0_op1),
      .i_req0_op2   (r0_op2),
      .i_req0_opsel (r0_sel),
      .i_req1_valid (v1),
      .o_req1_ready (ready1[li]),
      .i_req1_op1   (r1_op1),
      .i_req1_op2   (r1_op2),
      .i_req1_opsel (r1_sel),
      .i_flush      (flush),
      .o_alu_op1    (alu_op1[li]),
      .o_alu_op2    (alu_op2[li]),
      .o_alu_opsel  (alu_sel[li]),
      .i_alu_out    (alu_out[li]),
      .o_rsp0_valid (rsp0[li]),
      .o_rsp1_valid (rsp1[li]),
      .o_rsp_data   (rsp_data[li]),
      .o_busy       (busy[li])
    );

    always @(posedge clk) begin
      dl[0] <= alu_f(alu_op1[li], alu_op2[li], alu_sel[li]);
      for (int k = 1; k < 4; k++) dl[k] <= dl[k-1];
    end
    assign alu_out[li] = dl[li];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    v0 = 1'b0; v1 = 1'b0; flush = 2'b00;
    r0_op1 = '0; r0_op2 = '0; r0_sel = '0;
    r1_op1 = '0; r1_op2 = '0; r1_sel = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({ready0, ready1, rsp0, rsp1, busy} !== 15'd0) begin
        fails++;
        $display("FAIL reset_ctrl cyc %0d got %b want 0", i, {ready0, ready1, rsp0, rsp1, busy});
      end
      checks++;
      if ({alu_op1, alu_op2, alu_sel, rsp_data} !== '0) begin
        fails++;
        $display("FAIL reset_data cyc %0d got %h want 0", i, {alu_op1, alu_op2, alu_sel, rsp_data});
      end
      step();
    end
  endtask

  task automatic test_single();
    do_reset();
    v0 = 1'b1; r0_op1 = 32'd5; r0_op2 = 32'd3; r0_sel = 4'd0;
    #1;
    checks++;
    if ({ready0, ready1} !== 6'b111_000) begin
      fails++;
      $display("FAIL single_grant got %b want 111000", {ready0, ready1});
    end
    checks++;
    if ({alu_op1[0], alu_op2[0], alu_sel[0]} !== {32'd5, 32'd3, 4'd0}) begin
      fails++;
      $display("FAIL single_alu_drive got %h/%h/%h want 5/3/0", alu_op1[0], alu_op2[0], alu_sel[0]);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if ({rsp0[0], rsp1[0], rsp_data[0]} !== {1'b1, 1'b0, 32'd8}) begin
      fails++;
      $display("FAIL single_rsp_lat1 got %b%b %0d want 10 8", rsp0[0], rsp1[0], rsp_data[0]);
    end
    checks++;
    if ({rsp0[1], rsp_data[1]} !== {1'b0, 32'd0}) begin
      fails++;
      $display("FAIL single_early_lat2 got %b %0d want 0 0", rsp0[1], rsp_data[1]);
    end
    step();
    #1;
    checks++;
    if ({rsp0[0], rsp_data[0]} !== {1'b0, 32'd0}) begin
      fails++;
      $display("FAIL single_pulse_lat1 got %b %0d want 0 0", rsp0[0], rsp_data[0]);
    end
    checks++;
    if ({rsp0[1], rsp1[1], rsp_data[1]} !== {1'b1, 1'b0, 32'd8}) begin
      fails++;
      $display("FAIL single_rsp_lat2 got %b%b %0d want 10 8", rsp0[1], rsp1[1], rsp_data[1]);
    end
    step();
    step();
    #1;
    checks++;
    if (busy !== 3'b000) begin
      fails++;
      $display("FAIL single_idle_busy got %b want 000", busy);
    end
  endtask

  task automatic test_back_to_back();
    logic exp0;
    do_reset();
    v0 = 1'b1; r0_op1 = 32'd10;  r0_op2 = 32'd1;  r0_sel = 4'd0;
    v1 = 1'b1; r1_op1 = 32'd100; r1_op2 = 32'd20; r1_sel = 4'd1;
    for (int i = 0; i < 6; i++) begin
      exp0 = (i % 2 == 0);
      #1;
      checks++;
      if ({ready0, ready1} !== {{3{exp0}}, {3{~exp0}}}) begin
        fails++;
        $display("FAIL b2b_grant cyc %0d got %b want r0=%b", i, {ready0, ready1}, exp0);
      end
      checks++;
      if (alu_op1[0] !== (exp0 ? 32'd10 : 32'd100)) begin
        fails++;
        $display("FAIL b2b_alu cyc %0d got %0d want %0d", i, alu_op1[0], exp0 ? 10 : 100);
      end
      if (i > 0) begin
        checks++;
        if ({rsp0[0], rsp1[0], rsp_data[0]} !== {~exp0, exp0, (exp0 ? 32'd80 : 32'd11)}) begin
          fails++;
          $display("FAIL b2b_rsp cyc %0d got %b%b %0d want %b%b %0d", i, rsp0[0], rsp1[0],
                   rsp_data[0], ~exp0, exp0, exp0 ? 80 : 11);
        end
        checks++;
        if (busy[0] !== 1'b1) begin
          fails++;
          $display("FAIL b2b_busy cyc %0d got %b want 1", i, busy[0]);
        end
      end
      step();
    end
    idle_inputs();
    #1;
    checks++;
    if ({ready0[0], ready1[0], rsp0[0], rsp1[0], rsp_data[0]} !== {4'b0001, 32'd80}) begin
      fails++;
      $display("FAIL b2b_tail got %b%b%b%b %0d want 0001 80", ready0[0], ready1[0], rsp0[0],
               rsp1[0], rsp_data[0]);
    end
  endtask

  // Latency-3 instance: req1 ops in flight are flushed; a req0 op survives.
  task automatic test_flush_inflight();
    for (int run = 0; run < 2; run++) begin
      do_reset();
      v1 = 1'b1; r1_op1 = 32'd50; r1_op2 = 32'd5; r1_sel = 4'd0;
      step();
      if (run == 1) begin
        v1 = 1'b0;
        v0 = 1'b1; r0_op1 = 32'd7; r0_op2 = 32'd2; r0_sel = 4'd0;
      end
      step();
      idle_inputs();
      flush = 2'b10;
      #1;
      checks++;
      if (busy[2] !== (run == 1)) begin
        fails++;
        $display("FAIL flush_busy run %0d got %b want %b", run, busy[2], run == 1);
      end
      step();
      flush = 2'b00;
      for (int c = 3; c < 6; c++) begin
        #1;
        checks++;
        if (rsp1[2] !== 1'b0) begin
          fails++;
          $display("FAIL flush_rsp1 run %0d t+%0d got %b want 0", run, c, rsp1[2]);
        end
        checks++;
        if ({rsp0[2], rsp_data[2]} !== ((run == 1 && c == 4) ? {1'b1, 32'd9} : {1'b0, 32'd0})) begin
          fails++;
          $display("FAIL flush_rsp0 run %0d t+%0d got %b %0d want %b", run, c, rsp0[2],
                   rsp_data[2], run == 1 && c == 4);
        end
        step();
      end
    end
  endtask

  task automatic test_flush_same_cycle();
    do_reset();
    v1 = 1'b1; r1_op1 = 32'd20; r1_op2 = 32'd22; r1_sel = 4'd0;
    step();
    v1 = 1'b0;
    v0 = 1'b1; r0_op1 = 32'd4; r0_op2 = 32'd4; r0_sel = 4'd0;
    flush = 2'b01;
    #1;
    checks++;
    if (ready0 !== 3'b111) begin
      fails++;
      $display("FAIL samecyc_ready got %b want 111", ready0);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (busy[1:0] !== 2'b10) begin
      fails++;
      $display("FAIL samecyc_busy got %b want 10", busy[1:0]);
    end
    for (int c = 1; c < 4; c++) begin
      checks++;
      if (rsp0 !== 3'b000) begin
        fails++;
        $display("FAIL samecyc_rsp0 t+%0d got %b want 000", c, rsp0);
      end
      if (c < 3) begin
        checks++;
        if ({rsp1[c], rsp_data[c]} !== {1'b1, 32'd42}) begin
          fails++;
          $display("FAIL samecyc_other t+%0d got %b %0d want 1 42", c, rsp1[c], rsp_data[c]);
        end
      end
      step();
      #1;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    v1 = 1'b1; r1_op1 = 32'd2; r1_op2 = 32'd2; r1_sel = 4'd0;
    step();
    v1 = 1'b0;
    v0 = 1'b1; r0_op1 = 32'd1; r0_op2 = 32'd1; r0_sel = 4'd0;
    step();
    v0 = 1'b1; v1 = 1'b1;
    #1;
    checks++;
    if ({busy[1], rsp1[1]} !== 2'b11) begin
      fails++;
      $display("FAIL areset_pre got %b want 11", {busy[1], rsp1[1]});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ready0, ready1, rsp0, rsp1, busy} !== 15'd0) begin
      fails++;
      $display("FAIL areset_ctrl got %b want 0", {ready0, ready1, rsp0, rsp1, busy});
    end
    checks++;
    if ({alu_op1, alu_op2, alu_sel, rsp_data} !== '0) begin
      fails++;
      $display("FAIL areset_data got %h want 0", {alu_op1, alu_op2, alu_sel, rsp_data});
    end
    step();
    idle_inputs();
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if ({rsp0, rsp1, busy} !== 9'd0) begin
        fails++;
        $display("FAIL areset_stale cyc %0d got %b want 0", c, {rsp0, rsp1, busy});
      end
      step();
    end
    v0 = 1'b1; v1 = 1'b1;
    #1;
    checks++;
    if ({ready0, ready1} !== 6'b111_000) begin
      fails++;
      $display("FAIL areset_first_grant got %b want 111000", {ready0, ready1});
    end
    step();
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_back_to_back();
    test_flush_inflight();
    test_flush_same_cycle();
    test_async_reset();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/main_alu_arbiter.md
Name: main_alu_arbiter

Overview:
- Shares the single registered main_alu between two requesters: req0 (execute pipeline) and req1 (multi-cycle helper unit, e.g. address/iteration sequencer).
- Performs per-cycle round-robin grant and drives the ALU operand/opsel inputs from the winner.
- Tracks each in-flight operation's owner through the ALU latency and returns the result to that owner as a one-cycle response pulse.
- Supports per-requester flush of in-flight work.

Parameters:
- XLEN, 32, operand/result width
- OPSEL_W, 4, ALU operation-select width
- ALU_LATENCY, 1, cycles from operands presented to main_alu until o_aluout is valid (1..4)

Ports:
- i_clk  in  1  clock, all state on rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_valid  in  1  requester 0 has an operation
- o_req0_ready  out  1  requester 0 granted this cycle (combinational)
- i_req0_op1  in  XLEN  requester 0 operand 1
- i_req0_op2  in  XLEN  requester 0 operand 2
- i_req0_opsel  in  OPSEL_W  requester 0 operation select
- i_req1_valid, o_req1_ready, i_req1_op1, i_req1_op2, i_req1_opsel  same as req0, for requester 1
- i_flush  in  2  bit n kills all in-flight ops of requester n, including one issuing this cycle
- o_alu_op1  out  XLEN  to main_alu i_op1
- o_alu_op2  out  XLEN  to main_alu i_op2
- o_alu_opsel  out  OPSEL_W  to main_alu i_opsel
- i_alu_out  in  XLEN  from main_alu o_aluout
- o_rsp0_valid  out  1  result for requester 0 (single-cycle pulse; no back-pressure)
- o_rsp1_valid  out  1  result for requester 1
- o_rsp_data  out  XLEN  result data, shared; qualified by o_rspN_valid
- o_busy  out  1  any op in flight

Behaviour:
- Reset (async assert, sync release):
  - pipeline valid bits cleared; RR pointer = 0 (req0 has priority)
  - all o_rsp*_valid = 0, o_busy = 0
  - o_alu_* = 0, o_rsp_data = 0
  - reset mid-operation drops all in-flight ops; no response is ever produced for them
- Grant, combinational, one issue per cycle max:
  - only one valid → that requester granted
  - both valid → requester indicated by RR pointer granted
  - neither valid → no grant
  - o_reqN_ready = grantN; handshake completes when valid & ready
  - ready never asserts without the matching valid
- RR pointer: on any issue, pointer ← the id NOT granted. It holds when idle.
- ALU drive:
  - o_alu_* = granted requester's op1/op2/opsel
  - no grant → all zeros (opsel 0)
- Tracking: shift register of ALU_LATENCY stages, each {valid, owner}.
  - stage 0 loads {issue, grant_id}; stages advance every cycle unconditionally.
- Response:
  - op issued in cycle t → o_rspN_valid = 1 in cycle t+ALU_LATENCY
  - o_rsp_data = i_alu_out passed through combinationally in that same cycle
  - o_rsp_data = 0 when no response is valid
- Flush:
  - i_flush[n] in cycle c clears valid of every stage owned by n
  - also suppresses the stage-0 load if req n issues in cycle c; the handshake still completes
  - also suppresses the output stage of cycle c (same-cycle response to n is killed)
  - the other requester is unaffected
- Back-to-back: full throughput, one op/cycle in any mix; both requesters continuously valid → strict alternation.
- o_busy = OR of stage valid bits after flush masking.

Decomposition:
- Shared package alu_arb_pkg:
  - XLEN/OPSEL_W defaults
  - req_id type (1 bit)
  - in-flight stage struct {valid, owner}
- One sub-module: rr_arbiter2
  - inputs: two valids, pointer
  - outputs: one-hot grant
  - owns the pointer register
- Tracking pipe and output mux live in main_alu_arbiter.

Test Plan:
- Reset, no requests → o_req*_ready=0, o_alu_*=0, o_rsp*_valid=0, o_busy=0 for 10 cycles.
- req0 only, op1=5, op2=3, opsel=0 (add), LAT=1 → ready0=1 in cycle t; o_rsp0_valid=1, o_rsp_data=8 in t+1; o_rsp1_valid stays 0.
- Both valid continuously for 6 cycles after reset → grants 0,1,0,1,0,1; responses alternate rsp0/rsp1 one cycle later; no idle cycles.
- LAT=3, req1 issues at t, t+1; i_flush=2'b10 at t+2 → no rsp1 at t+3 or t+4; a req0 op issued at t+1 instead still responds at t+4.
- Flush same cycle as issue: req0 valid, i_flush=2'b01 at t → ready0=1 at t, no rsp0 at t+LAT, o_busy=0 at t+1.
- Async reset asserted mid-cycle with 2 ops in flight (LAT=2) → outputs go to 0 immediately; after release no stale responses; first grant goes to req0.
